// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package riscv_fetch_pkg;

  typedef enum logic [0:0] {RUN, FLUSH} fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, data} entries; flush wins over push and pop.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(QDEPTH):0]  count
);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: in-order imem requests under a credit limit, response queue, redirect flush.
// Build option IFU_MISALIGN_CHECK_EN adds a sticky misalign flag that halts fetch.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);
  localparam int unsigned CW  = $clog2(QDEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;

  logic [31:0]   fetch_pc_q, resp_pc_q, last_pc_q, target_pc;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, q_count;
  fetch_state_t  state_q, state_d;
  fetch_entry_t  head, rsp_entry;
  logic          halt, credit, req_fire, push, pop;

  assign target_pc = {redirect_pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst)                 misalign_q <= 1'b0;
    else if (redirect_valid) misalign_q <= |redirect_pc[1:0];
  end

  assign halt     = misalign_q;
  assign misalign = misalign_q;
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign halt           = 1'b0;
`endif

  // Stale in-flight requests still hold credit until their responses drain.
  assign credit         = ({1'b0, outstanding_q} + {1'b0, q_count}) < CW1'(QDEPTH);
  assign imem_req_valid = !rst && credit && !halt;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push      = imem_rsp_valid && (state_q == RUN) && !redirect_valid;
  assign pop       = inst_valid && inst_ready;
  assign rsp_entry = '{pc: resp_pc_q, data: imem_rsp_data};

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    // Everything still in flight after this cycle predates the redirect.
    if (redirect_valid) begin
      drop_cnt_d = outstanding_d;
    end else if (imem_rsp_valid && (state_q == FLUSH)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
    state_d = (drop_cnt_d != '0) ? FLUSH : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      state_q       <= RUN;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
      if (inst_valid) last_pc_q <= head.pc;
      if (redirect_valid) begin
        fetch_pc_q <= target_pc;
        resp_pc_q  <= target_pc;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push)     resp_pc_q  <= resp_pc_q + 32'd4;
      end
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (rsp_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (q_count)
  );

  assign inst_valid = (q_count != '0);
  assign inst_data  = inst_valid ? head.data : INSTR_NOP;
  assign inst_pc    = inst_valid ? head.pc : last_pc_q;
  assign inst_pc4   = inst_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming/stall vector table plus redirect,
// flush, wrap and reset sequences against a variable-latency memory model.
module tb_instr_fetch_unit;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .misalign       (misalign)
`endif
  );

  // Memory model: in-order, fixed latency, data = addr ^ A5A5_0000.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          lat = 1;
  int          edge_n = 0;
  logic        s_rst = 1'b1, s_acc = 1'b0, s_rsp = 1'b0;
  logic [31:0] s_addr = '0;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      edge_n++;
      if (s_rst) begin
        mq.delete();
      end else begin
        if (s_rsp && mq.size() > 0) void'(mq.pop_front());
        if (s_acc) mq.push_back('{s_addr, edge_n + lat - 1});
      end
      if (mq.size() > 0 && mq[0].due <= edge_n) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].addr ^ 32'hA5A5_0000;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #4;
      s_rst  = rst;
      s_acc  = imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      s_rsp  = imem_rsp_valid;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_inst(input string name, input logic v, input logic [31:0] pc);
    check({name, " inst_valid"}, 32'(inst_valid), 32'(v));
    check({name, " inst_pc"}, inst_pc, pc);
    check({name, " inst_pc4"}, inst_pc4, pc + 32'd4);
    check({name, " inst_data"}, inst_data, v ? mdata(pc) : INSTR_NOP);
  endtask

  // Leaves the bench at the negedge that starts cycle c0 with rst low.
  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1; lat = l;
    @(negedge clk); #1;
    check("rst req_valid", 32'(imem_req_valid), 32'd0);
    check("rst req_addr", imem_req_addr, 32'h0);
    check_inst("rst", 1'b0, 32'h0);
    check("rst drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    check("rst state", 32'(dut.state_q), 32'(RUN));
`ifdef IFU_MISALIGN_CHECK_EN
    check("rst misalign", 32'(misalign), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic redirect_at_next(input logic [31:0] pc);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  typedef struct {
    logic        ready;
    logic        req_v;
    logic [31:0] req_addr;
    logic        inst_v;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[$];

  initial begin
    // Streaming with 1-cycle memory, then 10 cycles of decode stall and drain.
    vt.push_back('{1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
    vt.push_back('{1'b1, 1'b1, 32'h04, 1'b0, 32'h00});
    vt.push_back('{1'b1, 1'b1, 32'h08, 1'b1, 32'h00});
    vt.push_back('{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04});
    vt.push_back('{1'b1, 1'b1, 32'h10, 1'b1, 32'h08});
    vt.push_back('{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C});
    vt.push_back('{1'b0, 1'b1, 32'h18, 1'b1, 32'h10});
    vt.push_back('{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10});
    for (int k = 0; k < 8; k++) vt.push_back('{1'b0, 1'b0, 32'h20, 1'b1, 32'h10});
    vt.push_back('{1'b1, 1'b0, 32'h20, 1'b1, 32'h10});
    vt.push_back('{1'b1, 1'b1, 32'h20, 1'b1, 32'h14});
    vt.push_back('{1'b1, 1'b1, 32'h24, 1'b1, 32'h18});
    vt.push_back('{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C});
    vt.push_back('{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20});
    vt.push_back('{1'b1, 1'b1, 32'h30, 1'b1, 32'h24});

    do_reset(1);
    for (int i = 0; i < vt.size(); i++) begin
      if (i > 0) @(negedge clk);
      inst_ready = vt[i].ready;
      #1;
      check($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].req_v));
      check($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].req_addr);
      check_inst($sformatf("vec%0d", i), vt[i].inst_v, vt[i].pc);
    end

    // 3-cycle memory, redirect with three requests in flight.
    do_reset(3);
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("lat3 c2 req_addr", imem_req_addr, 32'h08);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check($sformatf("lat3 c%0d drop_cnt", c), 32'(dut.drop_cnt_q), 32'(6 - c));
      check($sformatf("lat3 c%0d state", c), 32'(dut.state_q), (c < 6) ? 32'(FLUSH) : 32'(RUN));
      check($sformatf("lat3 c%0d inst_valid", c), 32'(inst_valid), 32'd0);
      check($sformatf("lat3 c%0d req_addr", c), imem_req_addr, 32'h100 + 32'(4 * (c - 3)));
    end
    @(negedge clk); #1;
    check_inst("lat3 target", 1'b1, 32'h100);

    // Redirect coinciding with a response, a request and an inst handshake.
    do_reset(1);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    check_inst("coin c3", 1'b1, 32'h04);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("coin c4 drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    check("coin c4 state", 32'(dut.state_q), 32'(FLUSH));
    check_inst("coin c4", 1'b0, 32'h04);
    check("coin c4 req_valid", 32'(imem_req_valid), 32'd1);
    check("coin c4 req_addr", imem_req_addr, 32'h200);
    @(negedge clk); #1;
    check("coin c5 state", 32'(dut.state_q), 32'(RUN));
    check("coin c5 inst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk); #1;
    check_inst("coin c6", 1'b1, 32'h200);
    @(negedge clk); #1;
    check_inst("coin c7", 1'b1, 32'h204);

    // Address wrap at the top of the 32-bit space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("wrap c8 req_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap c9 req_addr", imem_req_addr, 32'h0000_0000);
    @(negedge clk); #1;
    check_inst("wrap c10", 1'b1, 32'hFFFF_FFFC);
    check("wrap c10 pc4", inst_pc4, 32'h0000_0000);
    @(negedge clk); #1;
    check_inst("wrap c11", 1'b1, 32'h0000_0000);

`ifdef IFU_MISALIGN_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    for (int c = 12; c <= 14; c++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check($sformatf("mis c%0d misalign", c), 32'(misalign), 32'd1);
      check($sformatf("mis c%0d req_valid", c), 32'(imem_req_valid), 32'd0);
      check($sformatf("mis c%0d inst_valid", c), 32'(inst_valid), 32'd0);
    end
    check("mis drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    redirect_at_next(32'h200);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("mis clr misalign", 32'(misalign), 32'd0);
    check("mis clr req_valid", 32'(imem_req_valid), 32'd1);
    check("mis clr req_addr", imem_req_addr, 32'h200);
    repeat (2) @(negedge clk);
    #1;
    check_inst("mis resume", 1'b1, 32'h200);
`else
    // Low target bits are dropped silently.
    redirect_valid = 1'b1; redirect_pc = 32'h302;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("low2 req_addr", imem_req_addr, 32'h300);
    repeat (2) @(negedge clk);
    #1;
    check_inst("low2 inst", 1'b1, 32'h300);
    redirect_at_next(32'h400);
    @(negedge clk);
    redirect_valid = 1'b0;
`endif

    // Mid-operation reset is checked inside do_reset.
    do_reset(1);
    repeat (2) @(negedge clk);
    #1;
    check_inst("post-rst c2", 1'b1, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of the combinational control unit. Holds the fetch PC, issues in-order requests to a variable-latency instruction memory, buffers returned words in a small queue, and presents one instruction at a time with its PC to decode. It consumes redirects (taken branch, JAL, JALR) from the control unit and ALU, and discards every in-flight fetch older than the redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- QDEPTH, 4, instruction queue depth and outstanding-request credit limit; power of two, 2..8.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address (bits [1:0] = 0).
- imem_rsp_valid  in  1  response valid; responses return in request order, one per cycle max.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  PCSel from the control unit, qualified by a handshaken instruction.
- redirect_pc  in  32  branch/jump target from the ALU.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode/execute consumes the instruction.
- inst_data  out  32  instruction word (drives IMEMout).
- inst_pc  out  32  PC of inst_data.
- inst_pc4  out  32  inst_pc + 4, link value for WBSel = 2.
- misalign  out  1  only with IFU_MISALIGN_CHECK_EN.

## Operation
- Request handshake: transfers when imem_req_valid && imem_req_ready. imem_req_addr and valid are held stable until accepted. After a transfer, fetch_pc += 4, wrapping modulo 2^32.
- Credit: imem_req_valid = 1 only when (outstanding + queue occupancy) < QDEPTH, using registered counts. outstanding counts accepted requests whose response has not arrived, including those marked for drop.
- Responses: if drop_cnt = 0, push {data, pc} into the queue. Otherwise discard and decrement drop_cnt. The response PC comes from a parallel in-order PC tag FIFO, or equivalently a resp_pc counter reloaded on redirect.
- Output: head of queue. Handshake is inst_valid && inst_ready. When the queue is empty, inst_valid = 0, inst_data = 32'h0000_0013 (NOP), and inst_pc holds its last value.
- FSM states:
  - RUN: drop_cnt = 0.
  - FLUSH: drop_cnt ≠ 0. New requests are still permitted in FLUSH.
  - FLUSH → RUN when the last stale response is discarded.
- Redirect has priority. On redirect_valid:
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - Queue cleared.
  - drop_cnt ← outstanding + (request accepted this cycle) − (response arriving this cycle).
  - A response arriving the same cycle is discarded.
  - A request accepted the same cycle carries the old address and counts as stale.
  - An inst handshake in the same cycle completes; that instruction is the redirecting one.
- Arithmetic: all PCs are 32-bit unsigned, wrap silently; inst_pc4 = inst_pc + 32'd4 modulo 2^32.

## Timing
- Reset values:
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - inst_valid = 0, inst_data = 32'h0000_0013, inst_pc = RESET_PC, inst_pc4 = RESET_PC + 4.
  - misalign = 0, drop_cnt = 0, state RUN, queue empty.
- Reset asserted mid-operation clears everything in the same edge. Responses to requests issued before reset are neither counted nor expected; the memory is reset alongside.
- First request is valid in the first cycle after rst deasserts.
- Latency: a response in cycle t gives inst_valid in cycle t+1. There is no bypass from imem_rsp_data to inst_data.
- With a 1-cycle memory, QDEPTH = 4 sustains 1 instruction per cycle.
- After a redirect in cycle t, the first request to the target is valid in cycle t+1.
- Full queue: no request issued; responses are never refused, which is guaranteed by the credit rule.

## Configuration
- IFU_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] ≠ 0 sets sticky misalign and halts fetch (imem_req_valid = 0). Stale drops still complete.
  - misalign is cleared by rst or by an aligned redirect, which resumes fetch.
- Not defined: the misalign port is absent and redirect_pc[1:0] is silently cleared.

## Structure
- Package riscv_fetch_pkg:
  - fetch_state_t enum {RUN, FLUSH}.
  - INSTR_NOP = 32'h0000_0013.
  - Queue entry struct {pc[31:0], data[31:0]}.
- Sub-module fetch_queue: synchronous FIFO, depth QDEPTH, with push/pop/flush and count output. Flush has priority over push and pop.

## Test plan
- Reset release, 1-cycle memory returning addr ^ 32'hA5A5_0000, inst_ready = 1 → requests 0x0, 0x4, 0x8, … on consecutive cycles; inst_pc follows the same sequence one per cycle after initial latency; inst_data matches; inst_pc4 = inst_pc + 4.
- inst_ready = 0 for 10 cycles → at most 4 requests accepted, then imem_req_valid = 0; resuming drains in order with no loss.
- 3-cycle memory latency with 3 outstanding requests, redirect to 0x100 → three stale responses dropped (state FLUSH for 3 responses); next inst_pc = 0x100.
- Redirect coinciding with a response and a request handshake → both dropped; drop_cnt is correct; no stale PC is ever presented.
- fetch_pc = 0xFFFF_FFFC → next request is 0x0000_0000; inst_pc4 for 0xFFFF_FFFC = 0x0.
- Macro on: redirect to 0x102 → misalign = 1, no requests issued; redirect to 0x200 → misalign = 0, fetch resumes at 0x200.
